// File: rtl/muldiv_unit_pkg.sv
// +--------------------------------------------------------------------+
// | muldiv_unit_pkg : shared encodings for the RV32M multiply/divide   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package muldiv_unit_pkg;

  localparam int c_XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } md_state_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic is_div;
    logic want_high;
    logic want_rem;
  } md_dec_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_sign_adjust.sv
// +--------------------------------------------------------------------+
// | muldiv_unit_sign_adjust : conditional two's complement negation    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module muldiv_unit_sign_adjust #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_mag,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_mag + WIDTH'(1)) : i_mag;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +--------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply (shift-add) / divide        |
// |               (restoring), fixed XLEN+1 cycle latency              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = c_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int c_CW = $clog2(XLEN);

  function automatic md_dec_t decode_op(input logic [2:0] f);
    md_dec_t d;
    d        = '0;
    d.is_div = f[2];
    case (md_op_e'(f))
      MD_MULH:   begin d.a_signed = 1'b1; d.b_signed = 1'b1; d.want_high = 1'b1; end
      MD_MULHSU: begin d.a_signed = 1'b1; d.want_high = 1'b1; end
      MD_MULHU:  d.want_high = 1'b1;
      MD_DIV:    begin d.a_signed = 1'b1; d.b_signed = 1'b1; end
      MD_REM:    begin d.a_signed = 1'b1; d.b_signed = 1'b1; d.want_rem = 1'b1; end
      MD_REMU:   d.want_rem = 1'b1;
      default:   ;
    endcase
    return d;
  endfunction

  md_state_e       r_state;
  logic [XLEN-1:0] r_acc;     // product high word / partial remainder
  logic [XLEN-1:0] r_lo;      // multiplier-then-product-low / dividend-then-quotient
  logic [XLEN-1:0] r_b;       // multiplicand / divisor magnitude
  logic [XLEN-1:0] r_a_raw;
  logic [c_CW-1:0] r_cnt;
  logic            r_is_div;
  logic            r_want_high;
  logic            r_want_rem;
  logic            r_neg;
  logic            r_divzero;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  md_dec_t           w_dec_in;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_fin_mag;
  logic [2*XLEN-1:0] w_fin_val;
  logic [XLEN-1:0]   w_fin_sel;
  logic [XLEN-1:0]   w_result_next;

  assign w_dec_in = decode_op(op);
  assign w_a_neg  = w_dec_in.a_signed & operand_a[XLEN-1];
  assign w_b_neg  = w_dec_in.b_signed & operand_b[XLEN-1];

  muldiv_unit_sign_adjust #(.WIDTH(XLEN)) u_abs_a (
    .i_mag (operand_a),
    .i_neg (w_a_neg),
    .o_val (w_a_mag)
  );

  muldiv_unit_sign_adjust #(.WIDTH(XLEN)) u_abs_b (
    .i_mag (operand_b),
    .i_neg (w_b_neg),
    .o_val (w_b_mag)
  );

  assign w_sum     = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
  assign w_rem_sh  = {r_acc, r_lo[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  // Remainder after a successful subtract is always below the divisor, so XLEN bits suffice.
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_b;

  assign w_fin_mag = r_is_div ? {{XLEN{1'b0}}, (r_want_rem ? r_acc : r_lo)} : {r_acc, r_lo};

  muldiv_unit_sign_adjust #(.WIDTH(2*XLEN)) u_fin (
    .i_mag (w_fin_mag),
    .i_neg (r_neg),
    .o_val (w_fin_val)
  );

  assign w_fin_sel = r_want_high ? w_fin_val[2*XLEN-1:XLEN] : w_fin_val[XLEN-1:0];

  always_comb begin
    w_result_next = w_fin_sel;
    if (r_is_div && r_divzero) begin
      w_result_next = r_want_rem ? r_a_raw : {XLEN{1'b1}};
    end else if (r_ovf) begin
      w_result_next = r_want_rem ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_a_raw     <= '0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_want_high <= 1'b0;
      r_want_rem  <= 1'b0;
      r_neg       <= 1'b0;
      r_divzero   <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_is_div    <= w_dec_in.is_div;
              r_want_high <= w_dec_in.want_high;
              r_want_rem  <= w_dec_in.want_rem;
              r_neg       <= (w_dec_in.is_div && w_dec_in.want_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
              r_divzero   <= (operand_b == '0);
              r_ovf       <= w_dec_in.is_div && w_dec_in.a_signed &&
                             (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b);
              r_a_raw     <= operand_a;
              r_acc       <= '0;
              r_b         <= w_dec_in.is_div ? w_b_mag : w_a_mag;
              r_lo        <= w_dec_in.is_div ? w_a_mag : w_b_mag;
              r_cnt       <= c_CW'(XLEN - 1);
              r_busy      <= 1'b1;
              r_state     <= ST_CALC;
            end
          end
          ST_CALC: begin
            if (r_is_div) begin
              r_acc <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
              r_lo  <= {r_lo[XLEN-2:0], w_ge};
            end else begin
              r_acc <= w_sum[XLEN:1];
              r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
            end
            if (r_cnt == '0) begin
              r_state <= ST_FINISH;
            end else begin
              r_cnt <= r_cnt - c_CW'(1);
            end
          end
          ST_FINISH: begin
            r_result <= w_result_next;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// +--------------------------------------------------------------------+
// | tb_muldiv_unit : scoreboard bench for muldiv_unit, directed vectors|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_exp = 32'd0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (a),
    .operand_b (b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("result_op%0d", e.op), result, e.exp);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that sampled start.
  task automatic launch(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] ex, input bit push);
    op = o; a = aa; b = bb; start = 1'b1;
    if (push) begin
      exp_q.push_back({o, ex});
      last_exp = ex;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int lat = 0;
    int bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd33);
    check({name, "_busy_cycles"}, 32'(bcnt), 32'd33);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [31:0] ex, input string name);
    @(posedge clk); #1;
    launch(o, aa, bb, ex, 1'b1);
    wait_done(name);
  endtask

  task automatic idle_watch(input string name);
    int cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check(name, 32'(cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    run(MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    run(MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
    run(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run(MD_MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780, "mul_shift");
    run(MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2");
    run(MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    run(MD_DIVU,   32'd100,        32'd7,         32'd14,        "divu_100_7");
    run(MD_REMU,   32'd100,        32'd7,         32'd2,         "remu_100_7");
    run(MD_DIV,    32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, "div_20_m6");
    run(MD_REM,    32'd20,         32'hFFFF_FFFA, 32'd2,         "rem_20_m6");
    run(MD_DIV,    32'hFFFF_FFEC,  32'hFFFF_FFFA, 32'd3,         "div_m20_m6");
    run(MD_REM,    32'hFFFF_FFEC,  32'hFFFF_FFFA, 32'hFFFF_FFFE, "rem_m20_m6");
    run(MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "divu_big");
    run(MD_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "remu_big");
    run(MD_DIV,    32'h0000_1234,  32'd0,         32'hFFFF_FFFF, "div_by0");
    run(MD_REM,    32'h0000_1234,  32'd0,         32'h0000_1234, "rem_by0");
    run(MD_DIVU,   32'h0000_1234,  32'd0,         32'hFFFF_FFFF, "divu_by0");
    run(MD_REMU,   32'hFFFF_1234,  32'd0,         32'hFFFF_1234, "remu_by0");
    run(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf");

    // Back-to-back: second start issued in the cycle right after done.
    @(posedge clk); #1;
    launch(MD_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_done("b2b_first");
    launch(MD_MUL, 32'd6, 32'd7, 32'd42, 1'b1);
    wait_done("b2b_second");

    // Start pulses while busy must not disturb the running operation.
    @(posedge clk); #1;
    launch(MD_MUL, 32'd3, 32'd5, 32'd15, 1'b1);
    fork
      wait_done("start_while_busy");
      begin
        repeat (5) @(posedge clk);
        #2;
        op = MD_DIVU; a = 32'd99; b = 32'd9; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
      end
    join

    // Flush mid-CALC: busy drops, no done, result held.
    @(posedge clk); #1;
    launch(MD_MUL, 32'd5, 32'd6, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    idle_watch("flush_no_done");
    check("flush_result_held", result, last_exp);
    run(MD_MULHU, 32'h8000_0000, 32'd2, 32'd1, "post_flush");

    // Flush and start in the same idle cycle: request dropped.
    @(posedge clk); #1;
    op = MD_MUL; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    idle_watch("flush_start_no_done");

    // Asynchronous reset mid-CALC clears outputs immediately.
    @(posedge clk); #1;
    launch(MD_MUL, 32'd9, 32'd9, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_watch("rst_mid_no_done");
    run(MD_MUL, 32'd9, 32'd9, 32'd81, "post_reset");

    @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
